// File: rtl/reset_sequencer.sv
// Staged reset controller: hold, filtered PLL lock, then timed
// release of active-low reset domains, restarting on sw request or lock loss.
module reset_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int HOLD_CYC   = 32,
  parameter int LOCK_FILT  = 8,
  parameter int STAGE_DLY  = 16
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  pll_locked,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] rst_n_o,
  output logic                  done,
  output logic                  sw_rst_ack,
  output logic [7:0]            lock_lost_cnt,
  output logic [1:0]            state_o
);

  localparam logic [1:0] HOLD      = 2'd0;
  localparam logic [1:0] WAIT_LOCK = 2'd1;
  localparam logic [1:0] RELEASE   = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  localparam int MAXC = (HOLD_CYC > STAGE_DLY) ? HOLD_CYC : STAGE_DLY;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int LW   = $clog2(LOCK_FILT) + 1;

  localparam logic [NUM_STAGES-1:0] FIRST = NUM_STAGES'(1);

  logic [1:0]            sync;
  logic                  lock_s;
  logic [CW-1:0]         cnt;
  logic [LW-1:0]         lock_cnt;
  logic                  lost;
  logic                  restart;
  logic [NUM_STAGES-1:0] next_rel;

  assign lock_s   = sync[1];
  assign lost     = !lock_s && (state_o == RELEASE || state_o == RUN);
  assign restart  = sw_rst_req || lost;
  assign next_rel = (rst_n_o << 1) | FIRST;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], pll_locked};
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_o       <= HOLD;
      cnt           <= '0;
      lock_cnt      <= '0;
      rst_n_o       <= '0;
      done          <= 1'b0;
      sw_rst_ack    <= 1'b0;
      lock_lost_cnt <= 8'd0;
    end else begin
      sw_rst_ack <= sw_rst_req;
      if (lost && lock_lost_cnt != 8'hff) begin
        lock_lost_cnt <= lock_lost_cnt + 8'd1;
      end
      if (restart) begin
        state_o  <= HOLD;
        cnt      <= '0;
        lock_cnt <= '0;
        rst_n_o  <= '0;
        done     <= 1'b0;
      end else begin
        unique case (state_o)
          HOLD: begin
            rst_n_o  <= '0;
            done     <= 1'b0;
            lock_cnt <= '0;
            if (cnt == CW'(HOLD_CYC - 1)) begin
              cnt     <= '0;
              state_o <= WAIT_LOCK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_LOCK: begin
            if (!lock_s) begin
              lock_cnt <= '0;
            end else if (lock_cnt == LW'(LOCK_FILT - 1)) begin
              lock_cnt <= '0;
              cnt      <= '0;
              rst_n_o  <= FIRST;
              // a single domain means the first release is also the last
              if (&FIRST) begin
                state_o <= RUN;
                done    <= 1'b1;
              end else begin
                state_o <= RELEASE;
              end
            end else begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end
          RELEASE: begin
            if (cnt == CW'(STAGE_DLY - 1)) begin
              cnt     <= '0;
              rst_n_o <= next_rel;
              if (&next_rel) begin
                state_o <= RUN;
                done    <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RUN: begin
            done <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
